// File: rtl/relu_maxpool_hwc.sv
`default_nettype none
// relu_maxpool_hwc: ReLU + KxK/stride-S max-pool with edge clipping over an int8 HWC map in 1-cycle sync RAM.
// Rev 1.0 - initial release.
module relu_maxpool_hwc #(
  parameter int DIM_IN  = 32,
  parameter int DIM_OUT = 16,
  parameter int CH      = 32,
  parameter int KERNEL  = 3,
  parameter int STRIDE  = 2,
  parameter int PADDING = 0,
  parameter int ADDR_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic        [ADDR_W-1:0] rd_addr,
  input  logic signed [7:0]        rd_data,
  output logic                     wr_en,
  output logic        [ADDR_W-1:0] wr_addr,
  output logic signed [7:0]        wr_data
);

  localparam int SW = ADDR_W + 2;
  localparam logic signed [SW-1:0] ZERO_S   = '0;
  localparam logic signed [SW-1:0] DIM_IN_S = SW'(DIM_IN);
  localparam logic signed [SW-1:0] CH_S     = SW'(CH);
  localparam logic signed [SW-1:0] STRIDE_S = SW'(STRIDE);
  localparam logic signed [SW-1:0] PAD_S    = SW'(PADDING);
  localparam logic [ADDR_W-1:0] ONE       = 1;
  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(KERNEL - 1);
  localparam logic [ADDR_W-1:0] LAST_O    = ADDR_W'(DIM_OUT - 1);
  localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(CH - 1);
  localparam logic [ADDR_W-1:0] DIM_OUT_U = ADDR_W'(DIM_OUT);
  localparam logic [ADDR_W-1:0] CH_U      = ADDR_W'(CH);
  localparam logic signed [7:0] MIN8      = 8'sh80;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_FIN} state_t;

  state_t state, state_nxt;
  logic [ADDR_W-1:0] oy, ox, c, ky, kx;
  logic signed [7:0] run_max;
  logic              pending;

  logic signed [SW-1:0] tap_y, tap_x, tap_addr;
  logic                 tap_in, last_tap, last_elem;
  logic signed [7:0]    fold_max;
  logic [ADDR_W-1:0]    elem_addr;

  // Tap coordinates are signed so that a negative window origin clips cleanly.
  always_comb begin
    tap_y     = $signed({2'b00, oy}) * STRIDE_S - PAD_S + $signed({2'b00, ky});
    tap_x     = $signed({2'b00, ox}) * STRIDE_S - PAD_S + $signed({2'b00, kx});
    tap_in    = (tap_y >= ZERO_S) && (tap_y < DIM_IN_S) && (tap_x >= ZERO_S) && (tap_x < DIM_IN_S);
    tap_addr  = $signed({2'b00, c}) + (tap_y * DIM_IN_S + tap_x) * CH_S;
    last_tap  = (ky == LAST_K) && (kx == LAST_K);
    last_elem = (oy == LAST_O) && (ox == LAST_O) && (c == LAST_C);
    elem_addr = c + (oy * DIM_OUT_U + ox) * CH_U;
    fold_max  = (pending && (rd_data > run_max)) ? rd_data : run_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ: begin
        busy  = 1'b1;
        rd_en = tap_in;
        if (last_tap) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        wr_en     = 1'b1;
        state_nxt = last_elem ? S_FIN : S_READ;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_addr = rd_en ? ADDR_W'(tap_addr) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oy      <= '0;
      ox      <= '0;
      c       <= '0;
      ky      <= '0;
      kx      <= '0;
      run_max <= '0;
      pending <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      pending <= rd_en;
      case (state)
        S_IDLE: if (start) begin
          oy <= '0;
          ox <= '0;
          c  <= '0;
          ky <= '0;
          kx <= '0;
        end
        S_READ: begin
          run_max <= ((ky == '0) && (kx == '0)) ? MIN8 : fold_max;
          if (kx == LAST_K) begin
            kx <= '0;
            ky <= (ky == LAST_K) ? '0 : ky + ONE;
          end else begin
            kx <= kx + ONE;
          end
        end
        // Result is latched here so wr_addr/wr_data hold after the write strobe.
        S_DRAIN: begin
          run_max <= fold_max;
          wr_data <= fold_max[7] ? 8'sd0 : fold_max;
          wr_addr <= elem_addr;
        end
        S_WRITE: begin
          if (c == LAST_C) begin
            c <= '0;
            if (ox == LAST_O) begin
              ox <= '0;
              oy <= (oy == LAST_O) ? '0 : oy + ONE;
            end else begin
              ox <= ox + ONE;
            end
          end else begin
            c <= c + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool_hwc.sv
`default_nettype none
// tb_relu_maxpool_hwc: random-stimulus scoreboard bench for relu_maxpool_hwc (small, padded, clipping geometry).
module tb_relu_maxpool_hwc;

  localparam int DIM_IN   = 8;
  localparam int DIM_OUT  = 5;
  localparam int CH       = 4;
  localparam int KERNEL   = 3;
  localparam int STRIDE   = 2;
  localparam int PADDING  = 1;
  localparam int ADDR_W   = 16;
  localparam int N_OUT    = DIM_OUT * DIM_OUT * CH;
  localparam int PASS_CYC = N_OUT * (KERNEL * KERNEL + 2) + 1;
  localparam int MEM_SZ   = DIM_IN * DIM_IN * CH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic signed [7:0] wr_data;
  logic signed [7:0] rd_q = '0;

  logic signed [7:0] mem [MEM_SZ];

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad = 0;
  int rd_count = 0;
  int wr_count = 0;
  int exp_reads = 0;
  int last_addr = 0;
  int last_data = 0;

  relu_maxpool_hwc #(
    .DIM_IN(DIM_IN), .DIM_OUT(DIM_OUT), .CH(CH), .KERNEL(KERNEL),
    .STRIDE(STRIDE), .PADDING(PADDING), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_q),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) rd_q <= (int'(rd_addr) < MEM_SZ) ? mem[int'(rd_addr)] : 8'sh55;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int idx(input int y, input int x, input int ch);
    return ch + (y * DIM_IN + x) * CH;
  endfunction

  // Reference: straight window max over the in-bounds taps, then ReLU.
  task automatic push_expected();
    for (int oy = 0; oy < DIM_OUT; oy++)
      for (int ox = 0; ox < DIM_OUT; ox++)
        for (int ch = 0; ch < CH; ch++) begin
          int m;
          wr_t e;
          m = -128;
          for (int ky = 0; ky < KERNEL; ky++)
            for (int kx = 0; kx < KERNEL; kx++) begin
              int y, x, v;
              y = oy * STRIDE - PADDING + ky;
              x = ox * STRIDE - PADDING + kx;
              if (y >= 0 && y < DIM_IN && x >= 0 && x < DIM_IN) begin
                v = mem[idx(y, x, ch)];
                exp_reads++;
                if (v > m) m = v;
              end
            end
          e.addr = ch + (oy * DIM_OUT + ox) * CH;
          e.data = (m < 0) ? 0 : m;
          exp_q.push_back(e);
        end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (!reset) begin
      if (rd_en) begin
        rd_count++;
        check("rd_addr_in_range", (int'(rd_addr) < MEM_SZ) ? 1 : 0, 1);
      end
      if (wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_write_queue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(wr_addr), e.addr);
          check("wr_data", int'(wr_data), e.data);
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("wr_addr_hold", int'(wr_addr), last_addr);
        check("wr_data_hold", int'(wr_data), last_data);
      end
    end
  end

  task automatic run_pass(input string tag, input int reset_at, input int dup_a, input int dup_b);
    int n;
    bit got;
    rd_count = 0;
    wr_count = 0;
    exp_reads = 0;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < PASS_CYC + 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == dup_a) || (n == dup_b);
      if (n == 1) check({tag, "_busy_first"}, busy, 1);
      if (reset_at != 0 && n == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_rd_en"}, rd_en, 0);
        check({tag, "_rst_wr_en"}, wr_en, 0);
        exp_q.delete();
        last_addr = 0;
        last_data = 0;
        wr_count = 0;
        rd_count = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check({tag, "_writes_after_reset"}, wr_count, 0);
        check({tag, "_reads_after_reset"}, rd_count, 0);
        check({tag, "_idle_after_reset"}, busy, 0);
        return;
      end
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_done_cycle"}, n, PASS_CYC);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_write_count"}, wr_count, N_OUT);
    check({tag, "_read_count"}, rd_count, exp_reads);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'(v);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
  endtask

  initial begin : stim
    int n, first, second;
    fill_const(0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_rd_addr", int'(rd_addr), 0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    @(negedge clk);
    reset = 1'b0;

    fill_const(-5);
    run_pass("neg5", 0, 0, 0);

    fill_const(-1);
    mem[idx(3, 3, 1)] = 8'sd100;
    run_pass("peak", 0, 0, 0);

    fill_const(0);
    mem[idx(7, 7, 3)] = 8'sd77;
    run_pass("corner", 0, 0, 0);

    for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'(-int'($urandom_range(0, 128)));
    mem[idx(4, 4, 2)] = 8'sd127;
    mem[idx(4, 5, 2)] = 8'sh80;
    run_pass("extreme", 0, 0, 0);

    fill_const(-128);
    run_pass("min", 0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run_pass("rand", 0, 0, 0);
    end

    fill_rand();
    run_pass("dupstart", 0, 10, 600);

    fill_rand();
    run_pass("abort", 300, 0, 0);
    run_pass("after_abort", 0, 0, 0);

    // start held through DONE re-triggers a second back-to-back pass
    fill_rand();
    rd_count = 0;
    wr_count = 0;
    exp_reads = 0;
    push_expected();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    first = 0;
    second = 0;
    while (second == 0 && n < 2 * PASS_CYC + 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) begin
        if (first == 0) first = n;
        else second = n;
      end
      if (first != 0 && n == first + 5) start = 1'b0;
    end
    check("hold_first_done", first, PASS_CYC);
    check("hold_second_done", second, 2 * PASS_CYC + 1);
    @(negedge clk);
    check("hold_write_count", wr_count, 2 * N_OUT);
    check("hold_read_count", rd_count, exp_reads);
    check("hold_queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relu_maxpool_hwc.md
Name: relu_maxpool_hwc

Overview:
- Stage directly downstream of the conv layer.
- Reads the int8 HWC feature map written by the conv requant/saturate step and applies ReLU plus a KxK, stride-S max-pool with edge clipping.
- Writes the pooled int8 HWC map for the next conv layer (32x32x32 -> 16x16x32 by default).
- Memory-mapped, start/done driven; one read and at most one write per cycle.

Parameters:
- DIM_IN, 32, input feature map width/height
- DIM_OUT, 16, output feature map width/height
- CH, 32, channel count, same for input and output
- KERNEL, 3, pool window side
- STRIDE, 2, window step
- PADDING, 0, window origin offset: start = o*STRIDE - PADDING
- ADDR_W, 16, address width of both memory ports

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one full layer pass; sampled only in IDLE
- busy  out  1  high from first READ cycle through last WRITE cycle
- done  out  1  single-cycle pulse after the final write
- rd_en  out  1  read strobe to the input map RAM
- rd_addr  out  ADDR_W  input address = c + (y*DIM_IN + x)*CH
- rd_data  in  8  signed int8; valid the cycle after rd_en (1-cycle sync RAM)
- wr_en  out  1  write strobe to the output map RAM
- wr_addr  out  ADDR_W  output address = c + (oy*DIM_OUT + ox)*CH
- wr_data  out  8  signed int8 pooled value

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, rd_en and wr_en all 0. rd_addr, wr_addr and wr_data are 0. All loop counters and the running max are 0.
- Loop order: oy outer, then ox, then c, then ky, then kx innermost.
- States:
  - IDLE: start=1 -> READ with all counters 0; otherwise stay.
  - READ: KERNEL*KERNEL cycles, one per tap (ky,kx).
    - Tap position: y = oy*STRIDE - PADDING + ky, x = ox*STRIDE - PADDING + kx.
    - Tap in bounds (0 <= y,x < DIM_IN): rd_en=1 with the matching rd_addr.
    - Tap out of bounds: rd_en=0. The cycle is still consumed, so timing is deterministic.
    - Never drive rd_en with an out-of-range address.
  - DRAIN: 1 cycle. The last tap's data is folded in.
  - WRITE: 1 cycle.
    - wr_en=1, wr_data = max(running_max, 0), i.e. ReLU applied after the max.
    - Then advance c/ox/oy and go to READ, or go to DONE after the last element.
  - DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Running max:
  - Signed 8-bit, preset to -128 at the first READ cycle of each output element.
  - Updated in the cycle after each issued read: max = (rd_data > max) ? rd_data : max, as a signed compare.
  - Elements whose window has no in-bounds tap write 0.
- Per-element cost is KERNEL*KERNEL + 2 cycles. N_out = DIM_OUT*DIM_OUT*CH.
- Timing: the start edge is sampled in IDLE; the first rd_en follows on the next cycle; done is high exactly N_out*(KERNEL*KERNEL+2)+1 cycles after the start edge. Default is 90113 cycles.
- Outside WRITE, wr_en=0 and wr_addr/wr_data hold their last values.
- start while not in IDLE is ignored, including in the DONE cycle.
- start held high re-triggers from IDLE on the cycle after DONE.
- Reset mid-pass aborts immediately, with no further reads or writes. A subsequent start restarts from element (0,0,0).
- Addresses are computed in ADDR_W bits with no wrap. Parameter sets must satisfy DIM_IN*DIM_IN*CH <= 2^ADDR_W.
- No arithmetic widening is needed; all values stay int8.

Test Plan:
1. Input all -5 (0xFB); pulse start -> 8192 writes, all wr_data=0. wr_addr covers 0..8191 once each, in increasing order. done pulses at cycle 90113, exactly 1 cycle wide.
2. Input all -1 except (y=2,x=2,c=5)=100 -> ch5 at (oy,ox) = (0,0), (0,1), (1,0), (1,1) = 100, i.e. wr_addr 5, 37, 517, 549. Every other output is 0.
3. Edge clipping: (y=31,x=31,c=31)=77, rest 0 -> output (15,15,31)=77 at wr_addr 8191. The (15,15) windows issue 4 reads each. rd_addr never exceeds 32767.
4. Extremes: one window holding -128 and 127, with input elsewhere ≤ 0 -> only the outputs whose windows include the 127 tap are 127; all others are 0. All-(-128) input -> all outputs 0.
5. Assert reset at cycle 1000 of a pass -> busy, rd_en and wr_en drop asynchronously and no writes follow. A new start gives a full, correct pass and done at 90113.
6. Pulse start again at cycles 10 and 50000 of a pass -> both ignored. Exactly one done and 8192 writes occur.
